// File: rtl/hoops_collision_compositor_pkg.sv
// Shared game definitions for the hoop pass/hit logic: FSM state encoding and colour constants.
package hoops_collision_compositor_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    INSIDE   = 2'd1,
    COOLDOWN = 2'd2
  } hoop_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  localparam int HIT_MIN_PIXELS_DEF  = 4;
  localparam int COOLDOWN_FRAMES_DEF = 30;
  localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/hoops_collision_compositor_if.sv
// Pixel-stream bundle between the object bitmaps / VGA timing and the hoop compositor.
interface hoops_collision_compositor_if;

  logic       startOfFrame;
  logic       hoopInsideRect;
  logic       hoopTopDR;
  logic       hoopBottomDR;
  logic [7:0] hoopRGB;
  logic       playerDR;
  logic [7:0] playerRGB;
  logic [7:0] backGroundRGB;
  logic [7:0] RGBout;
  logic       hoopPassed;
  logic       hoopHit;
  logic [1:0] hoopState;

  modport master (
    output startOfFrame, hoopInsideRect, hoopTopDR, hoopBottomDR, hoopRGB,
    output playerDR, playerRGB, backGroundRGB,
    input  RGBout, hoopPassed, hoopHit, hoopState
  );

  modport slave (
    input  startOfFrame, hoopInsideRect, hoopTopDR, hoopBottomDR, hoopRGB,
    input  playerDR, playerRGB, backGroundRGB,
    output RGBout, hoopPassed, hoopHit, hoopState
  );

endinterface

// File: rtl/hoops_collision_compositor_frame_overlap_counter.sv
// Saturating per-frame pixel counter; on each frame start it latches (count >= THRESHOLD)
// and restarts with the coincident pixel's contribution.
module frame_overlap_counter #(
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start_of_frame,
  input  logic hit,
  output logic flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   THR     = (CNT_W+1)'(THRESHOLD);

  logic [CNT_W-1:0] cnt_reg;
  logic             flag_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else if (start_of_frame) begin
      flag_reg <= ({1'b0, cnt_reg} >= THR);
      cnt_reg  <= hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign flag = flag_reg;

endmodule

// File: rtl/hoops_collision_compositor.sv
// Layers the hoop ring around the player (bottom half in front, top half behind) and
// runs a once-per-frame FSM that reports a clean pass or a ring crash.
module hoops_collision_compositor
  import hoops_collision_compositor_pkg::*;
#(
  parameter int HIT_MIN_PIXELS  = HIT_MIN_PIXELS_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic                          clk,
  input logic                          reset,
  hoops_collision_compositor_if.slave  bus
);

  localparam int            CD_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES - 1);

  logic ring_hit, rect_hit;
  logic ring_flag, rect_flag;

  assign ring_hit = bus.playerDR && (bus.hoopTopDR || bus.hoopBottomDR);
  assign rect_hit = bus.playerDR && bus.hoopInsideRect;

  frame_overlap_counter #(.CNT_W(CNT_W), .THRESHOLD(HIT_MIN_PIXELS)) u_ring_cnt (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (bus.startOfFrame),
    .hit            (ring_hit),
    .flag           (ring_flag)
  );

  // A threshold of one is the same test as "count is non-zero".
  frame_overlap_counter #(.CNT_W(CNT_W), .THRESHOLD(1)) u_rect_cnt (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (bus.startOfFrame),
    .hit            (rect_hit),
    .flag           (rect_flag)
  );

  logic [7:0] rgb_reg, rgb_next;

  always_comb begin
    rgb_next = bus.backGroundRGB;
    if (bus.hoopBottomDR)   rgb_next = bus.hoopRGB;
    else if (bus.playerDR)  rgb_next = bus.playerRGB;
    else if (bus.hoopTopDR) rgb_next = bus.hoopRGB;
  end

  // The first frame start after reset only arms evaluation; the partial frame before it is discarded.
  logic armed_reg, eval_reg;

  hoop_state_t     state_reg, state_next;
  logic [CD_W-1:0] cd_reg, cd_next;
  logic            passed_reg, passed_next;
  logic            hit_reg, hit_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_reg    <= 8'h00;
      armed_reg  <= 1'b0;
      eval_reg   <= 1'b0;
      state_reg  <= CLEAR;
      cd_reg     <= '0;
      passed_reg <= 1'b0;
      hit_reg    <= 1'b0;
    end else begin
      rgb_reg    <= rgb_next;
      armed_reg  <= armed_reg | bus.startOfFrame;
      eval_reg   <= bus.startOfFrame & armed_reg;
      state_reg  <= state_next;
      cd_reg     <= cd_next;
      passed_reg <= passed_next;
      hit_reg    <= hit_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cd_next     = cd_reg;
    passed_next = 1'b0;
    hit_next    = 1'b0;
    case (state_reg)
      CLEAR: begin
        if (eval_reg) begin
          if (ring_flag) begin
            hit_next   = 1'b1;
            state_next = COOLDOWN;
            cd_next    = CD_LOAD;
          end else if (rect_flag) begin
            state_next = INSIDE;
          end
        end
      end
      INSIDE: begin
        if (eval_reg) begin
          if (ring_flag) begin
            hit_next   = 1'b1;
            state_next = COOLDOWN;
            cd_next    = CD_LOAD;
          end else if (!rect_flag) begin
            passed_next = 1'b1;
            state_next  = COOLDOWN;
            cd_next     = CD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (eval_reg) begin
          if (cd_reg == '0) state_next = CLEAR;
          else              cd_next    = cd_reg - CD_W'(1);
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign bus.RGBout     = rgb_reg;
  assign bus.hoopPassed = passed_reg;
  assign bus.hoopHit    = hit_reg;
  assign bus.hoopState  = state_reg;

endmodule

// File: tb/tb_hoops_collision_compositor.sv
// Directed bench for the hoop compositor: layering, pass/hit FSM, cooldown, frame-boundary and saturation cases.
module tb_hoops_collision_compositor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hoops_collision_compositor_if bus ();
  hoops_collision_compositor_if bus4 ();

  assign bus4.startOfFrame   = bus.startOfFrame;
  assign bus4.hoopInsideRect = bus.hoopInsideRect;
  assign bus4.hoopTopDR      = bus.hoopTopDR;
  assign bus4.hoopBottomDR   = bus.hoopBottomDR;
  assign bus4.hoopRGB        = bus.hoopRGB;
  assign bus4.playerDR       = bus.playerDR;
  assign bus4.playerRGB      = bus.playerRGB;
  assign bus4.backGroundRGB  = bus.backGroundRGB;

  hoops_collision_compositor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow counters so a single frame can drive the rect counter into saturation.
  hoops_collision_compositor #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pass_cnt = 0;
  int hit_cnt  = 0;
  int both_cnt = 0;
  int p0, h0;

  always @(negedge clk) begin
    if (bus.hoopPassed) pass_cnt++;
    if (bus.hoopHit) hit_cnt++;
    if (bus.hoopPassed && bus.hoopHit) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic px(input logic sof, input logic rect, input logic top, input logic bot, input logic player);
    bus.startOfFrame   = sof;
    bus.hoopInsideRect = rect;
    bus.hoopTopDR      = top;
    bus.hoopBottomDR   = bot;
    bus.playerDR       = player;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    px(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame boundary plus one pixel, after which the evaluation result is visible.
  task automatic close_frame();
    px(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic rect_frame(input int n);
    repeat (n) px(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic outside_frame(input int n);
    repeat (n) px(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ring_frame(input int n);
    repeat (n) px(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic cooldown_out();
    repeat (30) begin
      idle();
      close_frame();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.startOfFrame   = 1'b0;
    bus.hoopInsideRect = 1'b0;
    bus.hoopTopDR      = 1'b0;
    bus.hoopBottomDR   = 1'b0;
    bus.playerDR       = 1'b0;
    bus.hoopRGB        = 8'h04;
    bus.playerRGB      = 8'h1C;
    bus.backGroundRGB  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rgb", bus.RGBout, 8'h00);
    check_eq("reset_state", bus.hoopState, 2'd0);
    check_eq("reset_pulses", {bus.hoopPassed, bus.hoopHit}, 2'b00);
    reset = 1'b0;

    // Layering
    px(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("layer_bottom_over_player", bus.RGBout, 8'h04);
    px(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("layer_player_over_top", bus.RGBout, 8'h1C);
    idle();
    check_eq("layer_background", bus.RGBout, 8'hAA);
    px(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("layer_top_only", bus.RGBout, 8'h04);
    close_frame();
    check_eq("arm_state", bus.hoopState, 2'd0);

    // Clean pass
    rect_frame(10);
    close_frame();
    check_eq("pass_inside", bus.hoopState, 2'd1);
    check_eq("pass_no_early_pulse", bus.hoopPassed, 1'b0);
    outside_frame(5);
    p0 = pass_cnt;
    close_frame();
    check_eq("pass_pulse", bus.hoopPassed, 1'b1);
    check_eq("pass_no_hit", bus.hoopHit, 1'b0);
    check_eq("pass_cooldown", bus.hoopState, 2'd2);
    idle();
    check_eq("pass_width", bus.hoopPassed, 1'b0);
    check_eq("pass_count", pass_cnt - p0, 1);

    // Cooldown: flags ignored for 29 boundaries, 30th returns to CLEAR
    p0 = pass_cnt;
    h0 = hit_cnt;
    for (int i = 0; i < 29; i++) begin
      if (i % 2 == 0) rect_frame(10);
      else            ring_frame(5);
      close_frame();
    end
    check_eq("cd_still_cooldown", bus.hoopState, 2'd2);
    check_eq("cd_no_pulses", (pass_cnt - p0) + (hit_cnt - h0), 0);
    outside_frame(1);
    close_frame();
    check_eq("cd_clear", bus.hoopState, 2'd0);
    rect_frame(10);
    close_frame();
    check_eq("cd_rearm_inside", bus.hoopState, 2'd1);
    outside_frame(2);
    close_frame();
    check_eq("cd_rearm_pass", bus.hoopPassed, 1'b1);

    // Ring hit vs. below-threshold
    cooldown_out();
    check_eq("hit_start_clear", bus.hoopState, 2'd0);
    rect_frame(10);
    close_frame();
    check_eq("hit_inside", bus.hoopState, 2'd1);
    ring_frame(3);
    close_frame();
    check_eq("hit_3px_state", bus.hoopState, 2'd1);
    check_eq("hit_3px_nohit", bus.hoopHit, 1'b0);
    p0 = pass_cnt;
    h0 = hit_cnt;
    ring_frame(4);
    close_frame();
    check_eq("hit_4px_pulse", bus.hoopHit, 1'b1);
    check_eq("hit_4px_nopass", bus.hoopPassed, 1'b0);
    check_eq("hit_4px_state", bus.hoopState, 2'd2);
    idle();
    check_eq("hit_width", bus.hoopHit, 1'b0);
    check_eq("hit_counts", {16'(hit_cnt - h0), 16'(pass_cnt - p0)}, {16'd1, 16'd0});

    // Ring pixel coincident with startOfFrame belongs to the new frame
    cooldown_out();
    repeat (3) px(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    px(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    check_eq("sof_old_frame_nohit", bus.hoopHit, 1'b0);
    check_eq("sof_old_frame_state", bus.hoopState, 2'd0);
    repeat (3) px(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    close_frame();
    check_eq("sof_new_frame_hit", bus.hoopHit, 1'b1);

    // Saturation: 32 rect pixels with a 4-bit counter must not wrap to zero
    cooldown_out();
    check_eq("sat_start_clear", bus4.hoopState, 2'd0);
    rect_frame(32);
    close_frame();
    check_eq("sat_wide_inside", bus.hoopState, 2'd1);
    check_eq("sat_narrow_inside", bus4.hoopState, 2'd1);

    // Reset mid-frame while INSIDE
    rect_frame(4);
    reset = 1'b1;
    px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("midrst_rgb", bus.RGBout, 8'h00);
    check_eq("midrst_state", bus.hoopState, 2'd0);
    check_eq("midrst_state_narrow", bus4.hoopState, 2'd0);
    check_eq("midrst_pulses", {bus.hoopPassed, bus.hoopHit}, 2'b00);
    reset = 1'b0;
    outside_frame(6);
    p0 = pass_cnt;
    h0 = hit_cnt;
    close_frame();
    check_eq("midrst_partial_no_event", (pass_cnt - p0) + (hit_cnt - h0), 0);
    check_eq("midrst_partial_state", bus.hoopState, 2'd0);
    rect_frame(5);
    close_frame();
    check_eq("midrst_resume_inside", bus.hoopState, 2'd1);

    check_eq("pulses_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
